// File: rtl/game_sprite_renderer_pkg.sv
// rtl/game_sprite_renderer_pkg.sv - shared types, geometry defaults and sine table
// Contents:
//   coord_t            10-bit screen coordinate
//   DEF_*              default sprite geometry
//   SINE_TABLE         16 x 8-bit sine samples, element 0 in the low byte
package game_sprite_renderer_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_PLAYER_X    = 64;
  localparam int DEF_PLAYER_SIZE = 16;
  localparam int DEF_U_WIDTH     = 48;
  localparam int DEF_U_HEIGHT    = 40;
  localparam int DEF_U_THICK     = 8;

  // Leftmost entry is index 15, rightmost is index 0.
  localparam logic [15:0][7:0] SINE_TABLE = {
    8'd79,  8'd38,  8'd11,  8'd1,   8'd11,  8'd38,  8'd79,  8'd128,
    8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177, 8'd128
  };

endpackage

// File: rtl/game_sprite_renderer_sine_rom.sv
// rtl/game_sprite_renderer_sine_rom.sv - combinational 16-entry sine lookup
// Ports:
//   idx    in  4  table index
//   value  out 8  sine sample for idx
module game_sprite_renderer_sine_rom
  import game_sprite_renderer_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] value
);

  assign value = SINE_TABLE[idx];

endmodule

// File: rtl/game_sprite_renderer.sv
// rtl/game_sprite_renderer.sv - per-pixel hit test for player, U obstacle and sine bars
// Ports:
//   clk, rst                          pixel clock, synchronous active-high reset
//   pix_x, pix_y                      current beam position
//   show_player, player_y             player enable and top row
//   u_x, u_y                          U obstacle top-left corner
//   x_offset, top_x, top_y            sine scroll phase, field left bound, top baseline
//   bottom_x, bottom_y                field right bound, bottom baseline (both exclusive)
//   bar_width, visible_width, height  bar period, drawn pixels per period, max amplitude
//   draw_player, draw_u, draw_double_sin   registered hit flags, one clk latency
module game_sprite_renderer
  import game_sprite_renderer_pkg::*;
#(
  parameter int PLAYER_X    = DEF_PLAYER_X,
  parameter int PLAYER_SIZE = DEF_PLAYER_SIZE,
  parameter int U_WIDTH     = DEF_U_WIDTH,
  parameter int U_HEIGHT    = DEF_U_HEIGHT,
  parameter int U_THICK     = DEF_U_THICK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       show_player,
  input  logic [9:0] player_y,
  input  logic [9:0] u_x,
  input  logic [9:0] u_y,
  input  logic [9:0] x_offset,
  input  logic [9:0] top_x,
  input  logic [9:0] top_y,
  input  logic [9:0] bottom_x,
  input  logic [9:0] bottom_y,
  input  logic [9:0] bar_width,
  input  logic [9:0] visible_width,
  input  logic [9:0] height,
  output logic       draw_player,
  output logic       draw_u,
  output logic       draw_double_sin
);

  localparam logic [10:0] PX_LO   = 11'(PLAYER_X);
  localparam logic [10:0] PX_HI   = 11'(PLAYER_X + PLAYER_SIZE);
  localparam logic [10:0] PSIZE11 = 11'(PLAYER_SIZE);
  localparam logic [10:0] UW11    = 11'(U_WIDTH);
  localparam logic [10:0] UH11    = 11'(U_HEIGHT);
  localparam coord_t      UT10    = 10'(U_THICK);
  localparam coord_t      URARM10 = 10'(U_WIDTH - U_THICK);
  localparam coord_t      UBASE10 = 10'(U_HEIGHT - U_THICK);

  // Range ends are formed at 11 bits so boxes near 1023 do not wrap.
  logic [10:0] px11, py11;
  assign px11 = {1'b0, pix_x};
  assign py11 = {1'b0, pix_y};

  logic player_hit;
  assign player_hit = show_player
                    && (px11 >= PX_LO) && (px11 < PX_HI)
                    && (py11 >= {1'b0, player_y})
                    && (py11 <  {1'b0, player_y} + PSIZE11);

  logic   u_in_box, u_hit;
  coord_t u_dx, u_dy;
  assign u_in_box = (px11 >= {1'b0, u_x}) && (px11 < {1'b0, u_x} + UW11)
                 && (py11 >= {1'b0, u_y}) && (py11 < {1'b0, u_y} + UH11);
  assign u_dx  = pix_x - u_x;
  assign u_dy  = pix_y - u_y;
  assign u_hit = u_in_box && ((u_dx < UT10) || (u_dx >= URARM10) || (u_dy >= UBASE10));

  // Sine bars: phase wraps naturally at 10 bits; a zero period is replaced by 1
  // for the divider and the result is masked off below.
  coord_t      phase, divisor, bar_idx, bar_rem, amp;
  logic [7:0]  sine_val;
  logic [17:0] amp_prod;
  logic        top_hit, bot_hit, sine_hit;

  assign phase   = pix_x - top_x + x_offset;
  assign divisor = (bar_width == 10'd0) ? 10'd1 : bar_width;
  assign bar_idx = phase / divisor;
  assign bar_rem = phase % divisor;

  game_sprite_renderer_sine_rom u_sine_rom (
    .idx   (4'(bar_idx)),
    .value (sine_val)
  );

  assign amp_prod = {10'd0, sine_val} * {8'd0, height};
  assign amp      = 10'(amp_prod >> 8);

  assign top_hit = (py11 >= {1'b0, top_y}) && (py11 < {1'b0, top_y} + {1'b0, amp});
  // bottom_y - amp <= pix_y rewritten as pix_y + amp >= bottom_y to avoid underflow.
  assign bot_hit = (pix_y < bottom_y) && (py11 + {1'b0, amp} >= {1'b0, bottom_y});

  assign sine_hit = (bar_width != 10'd0)
                 && (pix_x >= top_x) && (pix_x < bottom_x)
                 && (bar_rem < visible_width)
                 && (top_hit || bot_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      draw_player     <= 1'b0;
      draw_u          <= 1'b0;
      draw_double_sin <= 1'b0;
    end else begin
      draw_player     <= player_hit;
      draw_u          <= u_hit;
      draw_double_sin <= sine_hit;
    end
  end

endmodule

// File: tb/tb_game_sprite_renderer.sv
// tb/tb_game_sprite_renderer.sv - directed self-checking bench for game_sprite_renderer
module tb_game_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pix_x, pix_y, player_y, u_x, u_y, x_offset;
  logic [9:0] top_x, top_y, bottom_x, bottom_y, bar_width, visible_width, height;
  logic       show_player;
  logic       draw_player, draw_u, draw_double_sin;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  game_sprite_renderer dut (
    .clk             (clk),
    .rst             (rst),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .show_player     (show_player),
    .player_y        (player_y),
    .u_x             (u_x),
    .u_y             (u_y),
    .x_offset        (x_offset),
    .top_x           (top_x),
    .top_y           (top_y),
    .bottom_x        (bottom_x),
    .bottom_y        (bottom_y),
    .bar_width       (bar_width),
    .visible_width   (visible_width),
    .height          (height),
    .draw_player     (draw_player),
    .draw_u          (draw_u),
    .draw_double_sin (draw_double_sin)
  );

  // Apply a pixel, let one edge register it, sample 1 ns later.
  task automatic step(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    @(posedge clk);
    #1;
  endtask

  task automatic sine_setup(input logic [9:0] off);
    top_x = 10'd100; top_y = 10'd180; bottom_x = 10'd540; bottom_y = 10'd400;
    bar_width = 10'd40; visible_width = 10'd25; height = 10'd60; x_offset = off;
  endtask

  task automatic test_reset;
    // Pixel (64,200) hits player, U left arm (u at 60,190) and sine bar k=1, r=24.
    rst = 1'b1;
    show_player = 1'b1; player_y = 10'd200;
    u_x = 10'd60; u_y = 10'd190;
    top_x = 10'd0; bottom_x = 10'd1000; top_y = 10'd190; bottom_y = 10'd1000;
    bar_width = 10'd40; visible_width = 10'd25; height = 10'd60; x_offset = 10'd0;
    step(10'd64, 10'd200);
    step(10'd64, 10'd200);
    checks++;
    if ({draw_player, draw_u, draw_double_sin} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold got %b want 000", {draw_player, draw_u, draw_double_sin});
    end
    rst = 1'b0;
    step(10'd64, 10'd200);
    checks++;
    if (draw_player !== 1'b1) begin errors++; $display("FAIL reset_release_player got %b want 1", draw_player); end
    checks++;
    if (draw_u !== 1'b1) begin errors++; $display("FAIL reset_release_u got %b want 1", draw_u); end
    checks++;
    if (draw_double_sin !== 1'b1) begin errors++; $display("FAIL reset_release_sin got %b want 1", draw_double_sin); end
  endtask

  task automatic test_player;
    logic [9:0] xs [4] = '{10'd64, 10'd80, 10'd79, 10'd64};
    logic [9:0] ys [4] = '{10'd200, 10'd200, 10'd215, 10'd200};
    logic       sh [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    u_x = 10'd900; u_y = 10'd900; bottom_x = 10'd0;
    player_y = 10'd200;
    for (int i = 0; i < 4; i++) begin
      show_player = sh[i];
      step(xs[i], ys[i]);
      checks++;
      if (draw_player !== ex[i]) begin
        errors++;
        $display("FAIL player_%0d (%0d,%0d) got %b want %b", i, xs[i], ys[i], draw_player, ex[i]);
      end
    end
  endtask

  task automatic test_u;
    logic [9:0] xs [6] = '{10'd300, 10'd347, 10'd348, 10'd324, 10'd324, 10'd324};
    logic [9:0] ys [6] = '{10'd100, 10'd100, 10'd100, 10'd110, 10'd135, 10'd140};
    logic       ex [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    u_x = 10'd300; u_y = 10'd100;
    for (int i = 0; i < 6; i++) begin
      step(xs[i], ys[i]);
      checks++;
      if (draw_u !== ex[i]) begin
        errors++;
        $display("FAIL u_%0d (%0d,%0d) got %b want %b", i, xs[i], ys[i], draw_u, ex[i]);
      end
    end
  endtask

  task automatic test_sine;
    logic [9:0] xs [7] = '{10'd100, 10'd100, 10'd130, 10'd140, 10'd100, 10'd100, 10'd540};
    logic [9:0] ys [7] = '{10'd190, 10'd215, 10'd190, 10'd220, 10'd399, 10'd400, 10'd190};
    logic       ex [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    sine_setup(10'd0);
    for (int i = 0; i < 7; i++) begin
      step(xs[i], ys[i]);
      checks++;
      if (draw_double_sin !== ex[i]) begin
        errors++;
        $display("FAIL sine_%0d (%0d,%0d) got %b want %b", i, xs[i], ys[i], draw_double_sin, ex[i]);
      end
    end
  endtask

  task automatic test_scroll;
    sine_setup(10'd30);
    step(10'd100, 10'd190);
    checks++;
    if (draw_double_sin !== 1'b0) begin errors++; $display("FAIL scroll_30 got %b want 0", draw_double_sin); end
    sine_setup(10'd40);
    step(10'd100, 10'd190);
    checks++;
    if (draw_double_sin !== 1'b1) begin errors++; $display("FAIL scroll_40 got %b want 1", draw_double_sin); end
    // Zero bar width forces the field off.
    bar_width = 10'd0;
    step(10'd100, 10'd190);
    checks++;
    if (draw_double_sin !== 1'b0) begin errors++; $display("FAIL bar_width_zero got %b want 0", draw_double_sin); end
  endtask

  task automatic test_latency;
    logic prev, cur;
    show_player = 1'b1; player_y = 10'd200;
    step(10'd60, 10'd200);
    prev = 1'b0;
    for (int x = 61; x <= 84; x++) begin
      cur = (x >= 64) && (x < 80);
      pix_x = 10'(x);
      #1;
      checks++;
      if (draw_player !== prev) begin
        errors++;
        $display("FAIL latency_early x=%0d got %b want %b", x, draw_player, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (draw_player !== cur) begin
        errors++;
        $display("FAIL latency_late x=%0d got %b want %b", x, draw_player, cur);
      end
      prev = cur;
    end
  endtask

  initial begin
    test_reset;
    test_player;
    test_u;
    test_sine;
    test_scroll;
    test_latency;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
